// File: rtl/hammer_pkg.sv
// hammer_pkg: shared Hamming(12,8) constants and encode function for the encoder/decoder pair.
package hammer_pkg;
    localparam int DATA_W = 8;
    localparam int CODE_W = 12;
    localparam int CHK_POS [4] = '{0, 1, 3, 7};
    localparam int DATA_POS [8] = '{2, 4, 5, 6, 8, 9, 10, 11};
    typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;
    function automatic logic [CODE_W-1:0] hammer_encode(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] c;
        c = '0;
        c[DATA_POS[0]] = d[0];
        c[DATA_POS[1]] = d[1];
        c[DATA_POS[2]] = d[2];
        c[DATA_POS[3]] = d[3];
        c[DATA_POS[4]] = d[4];
        c[DATA_POS[5]] = d[5];
        c[DATA_POS[6]] = d[6];
        c[DATA_POS[7]] = d[7];
        c[CHK_POS[0]] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
        c[CHK_POS[1]] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
        c[CHK_POS[2]] = d[1] ^ d[2] ^ d[3] ^ d[7];
        c[CHK_POS[3]] = d[4] ^ d[5] ^ d[6] ^ d[7];
        return c;
    endfunction
endpackage

// File: rtl/hammer_encode_comb.sv
// hammer_encode_comb: combinational 8-bit data to 12-bit Hamming codeword.
module hammer_encode_comb
    import hammer_pkg::*;
(
    input  logic [DATA_W-1:0] i_data,
    output logic [CODE_W-1:0] o_code
);
    assign o_code = hammer_encode(i_data);
endmodule

// File: rtl/hammer_encoder_stream.sv
// hammer_encoder_stream: streaming Hamming(12,8) encoder with a two-entry skid buffer and word counter.
// Optional one-shot codeword bit-flip injection under HAMMER_ERR_INJECT_EN.
module hammer_encoder_stream
    import hammer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic [CNT_W-1:0]  word_count
`ifdef HAMMER_ERR_INJECT_EN
    ,
    input  logic              inj_req,
    input  logic [3:0]        inj_pos,
    output logic              inj_pending
`endif
);
    occ_t r_state, w_next;
    logic r_in_ready, r_out_valid;
    logic [CODE_W-1:0] r_main, r_skid, w_clean, w_code;
    logic [CNT_W-1:0] r_count;
    logic w_acc, w_pop, w_load_main, w_load_skid, w_shift;

    hammer_encode_comb u_enc (.i_data(in_data), .o_code(w_clean));

    assign w_acc = in_valid && r_in_ready;
    assign w_pop = r_out_valid && out_ready;

`ifdef HAMMER_ERR_INJECT_EN
    logic r_inj_pending, w_arm;
    logic [3:0] r_inj_pos, w_pos;
    // A request in the same cycle as an accept applies immediately and never arms.
    assign w_arm = inj_req && (inj_pos < 4'd12);
    assign w_pos = w_arm ? inj_pos : r_inj_pos;
    assign w_code = (w_arm || r_inj_pending) ? w_clean ^ (CODE_W'(1) << w_pos) : w_clean;
    assign inj_pending = r_inj_pending;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inj_pending <= 1'b0;
            r_inj_pos <= '0;
        end else if (w_acc) begin
            r_inj_pending <= 1'b0;
        end else if (w_arm) begin
            r_inj_pending <= 1'b1;
            r_inj_pos <= inj_pos;
        end
    end
`else
    assign w_code = w_clean;
`endif

    always_comb begin
        w_next = r_state;
        w_load_main = 1'b0;
        w_load_skid = 1'b0;
        w_shift = 1'b0;
        case (r_state)
            EMPTY: begin
                w_load_main = w_acc;
                w_next = w_acc ? ONE : EMPTY;
            end
            ONE: begin
                w_load_main = w_acc && w_pop;
                w_load_skid = w_acc && !w_pop;
                w_next = w_load_skid ? TWO : (w_pop && !w_acc) ? EMPTY : ONE;
            end
            TWO: begin
                w_shift = w_pop;
                w_next = w_pop ? ONE : TWO;
            end
            default: w_next = EMPTY;
        endcase
    end

    // Handshake outputs are registered from the next state so neither depends on out_ready combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_in_ready <= 1'b0;
            r_out_valid <= 1'b0;
            r_main <= '0;
            r_skid <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            r_in_ready <= (w_next != TWO);
            r_out_valid <= (w_next != EMPTY);
            if (w_load_main) r_main <= w_code;
            else if (w_shift) r_main <= r_skid;
            if (w_load_skid) r_skid <= w_code;
            if (w_acc) r_count <= r_count + 1'b1;
        end
    end

    assign in_ready = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_code = r_main;
    assign word_count = r_count;
endmodule

// File: tb/tb_hammer_encoder_stream.sv
// tb_hammer_encoder_stream: directed self-checking bench for hammer_encoder_stream.
module tb_hammer_encoder_stream;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic in_ready, out_valid;
    logic [11:0] out_code;
    logic [15:0] word_count;
`ifdef HAMMER_ERR_INJECT_EN
    logic inj_req = 1'b0, inj_pending;
    logic [3:0] inj_pos = 4'd0;
`endif
    int n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;

    hammer_encoder_stream #(.CNT_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_code(out_code),
        .word_count(word_count)
`ifdef HAMMER_ERR_INJECT_EN
        ,
        .inj_req(inj_req),
        .inj_pos(inj_pos),
        .inj_pending(inj_pending)
`endif
    );

    function automatic logic [11:0] ref_code(input logic [7:0] d);
        return {d[7:4], ^(d & 8'hF0), d[3:1], ^(d & 8'h8E), d[0], ^(d & 8'h6D), ^(d & 8'h5B)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [7:0] sb[$];
        int nxt, got, acc_low, seen;
        in_valid = 1'b1;
        in_data = 8'h39;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_code", out_code, 0);
        chk("rst_count", word_count, 0);
        in_valid = 1'b0;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", in_ready, 1);
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_count", word_count, 0);

        in_valid = 1'b1;
        in_data = 8'h39;
        @(negedge clk);
        in_valid = 1'b0;
        chk("single_valid", out_valid, 1);
        chk("single_code", out_code, 12'h34F);
        chk("single_count", word_count, 1);
        @(negedge clk);
        chk("single_drained", out_valid, 0);

        in_valid = 1'b1;
        in_data = 8'h00;
        @(negedge clk);
        chk("b2b_code0", out_code, 12'h000);
        chk("b2b_valid0", out_valid, 1);
        chk("b2b_ready0", in_ready, 1);
        in_data = 8'hFF;
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_code1", out_code, 12'hF77);
        chk("b2b_ready1", in_ready, 1);
        @(negedge clk);

        nxt = 1;
        got = 0;
        acc_low = 0;
        for (int c = 0; c < 200 && got < 16; c++) begin
            out_ready = (c >= 3);
            in_valid = (nxt <= 16);
            in_data = nxt[7:0];
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("stream_extra", 1, 0);
                else chk("stream_code", out_code, ref_code(sb.pop_front()));
                got++;
            end
            if (in_valid && in_ready) begin
                sb.push_back(in_data);
                nxt++;
                if (c < 3) acc_low++;
            end
            if (c == 2) chk("stall_ready", in_ready, 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stall_accepts", acc_low, 2);
        chk("stream_count", got, 16);
        @(negedge clk);

        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'hA5;
        @(negedge clk);
        in_data = 8'h5A;
        @(negedge clk);
        in_valid = 1'b0;
        chk("two_ready", in_ready, 0);
        chk("two_valid", out_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_count", word_count, 0);
        chk("midrst_ready", in_ready, 0);
        out_ready = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midrst_flushed", seen, 0);

`ifdef HAMMER_ERR_INJECT_EN
        inj_req = 1'b1;
        inj_pos = 4'd5;
        @(negedge clk);
        inj_req = 1'b0;
        chk("inj_armed", inj_pending, 1);
        in_valid = 1'b1;
        in_data = 8'h39;
        @(negedge clk);
        in_valid = 1'b0;
        chk("inj_code", out_code, 12'h36F);
        chk("inj_cleared", inj_pending, 0);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("inj_oneshot", out_code, 12'h34F);
        inj_req = 1'b1;
        inj_pos = 4'd13;
        @(negedge clk);
        inj_req = 1'b0;
        chk("inj_badpos", inj_pending, 0);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("inj_badpos_code", out_code, 12'h34F);
        inj_req = 1'b1;
        inj_pos = 4'd0;
        in_valid = 1'b1;
        @(negedge clk);
        inj_req = 1'b0;
        in_valid = 1'b0;
        chk("inj_same_cycle", out_code, 12'h34E);
        chk("inj_same_pending", inj_pending, 0);
        @(negedge clk);
`endif

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        out_ready = 1'b1;
        repeat (65535) begin
            in_data = in_data + 8'd1;
            @(negedge clk);
        end
        chk("cnt_max", word_count, 16'hFFFF);
        @(negedge clk);
        in_valid = 1'b0;
        chk("cnt_wrap", word_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
